// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS-lite datapath.
// Sequences fetch/decode/execute/memory/writeback, produces the ALUOp pair,
// all datapath strobes and mux selects, and stalls on mem_ready.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode traps to state 13
// instead of being retired as a NOP).
module multicycle_control #(
  parameter logic [5:0] OP_NORI     = 6'b011000,
  parameter logic [5:0] FUNCT_BRV   = 6'b010100,
  parameter logic [5:0] FUNCT_JMXOR = 6'b100001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_RTPC   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite;
  logic       w_irwrite, w_memtoreg, w_regdst, w_regwrite, w_alusrca;
  logic [1:0] w_alusrcb, w_pcsource, w_aluop;
  logic       w_instr_done, w_illegal;

  // State register; reset returns the sequencer to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode (memory strobes qualified by mem_ready).
  always_comb begin
    w_next        = S_FETCH;
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_pcsource    = 2'b00;
    w_aluop       = 2'b00;
    w_instr_done  = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTEXEC;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JUMP;
          OP_NORI:      w_next = S_IEXEC;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            // Unknown opcode retires as a NOP.
            w_next       = S_FETCH;
            w_instr_done = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_next    = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_regwrite   = 1'b1;
        w_memtoreg   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWR: begin
        w_memwrite   = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = mem_ready;
        w_next       = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        if ((funct == FUNCT_BRV) || (funct == FUNCT_JMXOR)) begin
          w_next = S_RTPC;
        end else begin
          w_next = S_RTWB;
        end
      end
      S_RTWB: begin
        w_regwrite   = 1'b1;
        w_regdst     = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_RTPC: begin
        w_pcwrite    = 1'b1;
        w_pcsource   = 2'b11;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BEQ: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
        w_instr_done  = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        w_pcwrite    = 1'b1;
        w_pcsource   = 2'b10;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_IEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = 2'b11;
        w_next    = S_IWB;
      end
      S_IWB: begin
        w_regwrite   = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        // Sticky trap: only reset leaves this state.
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
`endif
      default: begin
        // Unused codes recover to FETCH with everything deasserted.
        w_next = S_FETCH;
      end
    endcase
  end

  // Strobes are suppressed while reset is held; selects follow the FETCH decode.
  assign pcwrite     = w_pcwrite     & rst_n;
  assign pcwritecond = w_pcwritecond & rst_n;
  assign memread     = w_memread     & rst_n;
  assign memwrite    = w_memwrite    & rst_n;
  assign irwrite     = w_irwrite     & rst_n;
  assign regwrite    = w_regwrite    & rst_n;
  assign instr_done  = w_instr_done  & rst_n;
  assign illegal     = w_illegal     & rst_n;
  assign iord        = w_iord;
  assign memtoreg    = w_memtoreg;
  assign regdst      = w_regdst;
  assign alusrca     = w_alusrca;
  assign alusrcb     = w_alusrcb;
  assign pcsource    = w_pcsource;
  assign aluop1      = w_aluop[1];
  assign aluop0      = w_aluop[0];
  assign state       = r_state;

  // zero is consumed by the datapath branch gating, not by the sequencer.
  logic w_unused;
  assign w_unused = zero;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks lw, R-type, brv, beq, nori,
// sw with stalls, reset mid-instruction and an unknown opcode.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic       aluop1, aluop0, instr_done, illegal;
  logic [3:0] state;

  int checks;
  int failures;
  int done_cnt;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
    .aluop1(aluop1), .aluop0(aluop0), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count retirement pulses seen at clock edges.
  always @(posedge clk) begin
    if (instr_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, let outputs settle.
  task automatic tick(input logic [5:0] o, input logic [5:0] f, input logic mr, input logic z);
    @(negedge clk);
    op = o; funct = f; mem_ready = mr; zero = z;
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0;
    rst_n = 1'b0; op = 6'b100011; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("rst_state",   {28'd0, state}, 32'd0);
    chk("rst_memread", {31'd0, memread}, 32'd0);
    chk("rst_pcwrite", {31'd0, pcwrite}, 32'd0);
    chk("rst_alusrcb", {30'd0, alusrcb}, 32'd1);
    rst_n = 1'b1;
    #1;
    // FETCH stalled: memread on, ready-qualified strobes off.
    chk("fstall_memread", {31'd0, memread}, 32'd1);
    chk("fstall_irwrite", {31'd0, irwrite}, 32'd0);

    // lw: 0,1,2,3,4
    tick(6'b100011, 6'd0, 1'b1, 1'b0);
    chk("lw_s0", {28'd0, state}, 32'd0);
    chk("lw_fetch_ir", {31'd0, irwrite}, 32'd1);
    chk("lw_fetch_pc", {31'd0, pcwrite}, 32'd1);
    done_cnt = 0;
    tick(6'b100011, 6'd0, 1'b1, 1'b0);
    chk("lw_s1", {28'd0, state}, 32'd1);
    chk("lw_dec_srcb", {30'd0, alusrcb}, 32'd3);
    tick(6'b100011, 6'd0, 1'b1, 1'b0);
    chk("lw_s2", {28'd0, state}, 32'd2);
    chk("lw_adr_src", {29'd0, alusrca, alusrcb}, 32'h6);
    tick(6'b100011, 6'd0, 1'b1, 1'b0);
    chk("lw_s3", {28'd0, state}, 32'd3);
    chk("lw_rd_mem", {30'd0, memread, iord}, 32'h3);
    tick(6'b100011, 6'd0, 1'b1, 1'b0);
    chk("lw_s4", {28'd0, state}, 32'd4);
    chk("lw_wb", {29'd0, regwrite, memtoreg, regdst}, 32'h6);
    chk("lw_wb_done", {31'd0, instr_done}, 32'd1);
    tick(6'b000000, 6'b100010, 1'b1, 1'b0);
    chk("lw_back_s0", {28'd0, state}, 32'd0);
    chk("lw_done_cnt", done_cnt, 32'd1);

    // R-type sub: 0,1,6,7
    tick(6'b000000, 6'b100010, 1'b1, 1'b0);
    chk("rt_s1", {28'd0, state}, 32'd1);
    tick(6'b000000, 6'b100010, 1'b1, 1'b0);
    chk("rt_s6", {28'd0, state}, 32'd6);
    chk("rt_aluop", {30'd0, aluop1, aluop0}, 32'd2);
    chk("rt_src", {29'd0, alusrca, alusrcb}, 32'h4);
    tick(6'b000000, 6'b100010, 1'b1, 1'b0);
    chk("rt_s7", {28'd0, state}, 32'd7);
    chk("rt_wb", {29'd0, regwrite, regdst, instr_done}, 32'h7);

    // brv: 0,1,6,12
    tick(6'b000000, 6'b010100, 1'b1, 1'b0);
    chk("brv_s0", {28'd0, state}, 32'd0);
    tick(6'b000000, 6'b010100, 1'b1, 1'b0);
    tick(6'b000000, 6'b010100, 1'b1, 1'b0);
    chk("brv_s6", {28'd0, state}, 32'd6);
    tick(6'b000000, 6'b010100, 1'b1, 1'b0);
    chk("brv_s12", {28'd0, state}, 32'd12);
    chk("brv_pc", {29'd0, pcwrite, pcsource}, 32'h7);
    chk("brv_noreg", {31'd0, regwrite}, 32'd0);

    // beq: 0,1,8 with mem_ready low in DECODE (ignored)
    tick(6'b000100, 6'd0, 1'b1, 1'b1);
    chk("beq_s0", {28'd0, state}, 32'd0);
    tick(6'b000100, 6'd0, 1'b0, 1'b1);
    chk("beq_s1", {28'd0, state}, 32'd1);
    tick(6'b000100, 6'd0, 1'b1, 1'b1);
    chk("beq_s8", {28'd0, state}, 32'd8);
    chk("beq_aluop", {30'd0, aluop1, aluop0}, 32'd1);
    chk("beq_pc", {28'd0, pcwritecond, pcsource, instr_done}, 32'hB);

    // nori: 0,1,10,11
    tick(6'b011000, 6'd0, 1'b1, 1'b0);
    chk("nori_s0", {28'd0, state}, 32'd0);
    tick(6'b011000, 6'd0, 1'b1, 1'b0);
    tick(6'b011000, 6'd0, 1'b1, 1'b0);
    chk("nori_s10", {28'd0, state}, 32'd10);
    chk("nori_aluop", {30'd0, aluop1, aluop0}, 32'd3);
    tick(6'b011000, 6'd0, 1'b1, 1'b0);
    chk("nori_s11", {28'd0, state}, 32'd11);
    chk("nori_wb", {29'd0, regwrite, regdst, instr_done}, 32'h5);

    // sw with three stall cycles in MEMWR
    tick(6'b101011, 6'd0, 1'b1, 1'b0);
    chk("sw_s0", {28'd0, state}, 32'd0);
    tick(6'b101011, 6'd0, 1'b1, 1'b0);
    tick(6'b101011, 6'd0, 1'b1, 1'b0);
    chk("sw_s2", {28'd0, state}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick(6'b101011, 6'd0, 1'b0, 1'b0);
      chk("sw_stall_s5", {28'd0, state}, 32'd5);
      chk("sw_stall_wr", {30'd0, memwrite, instr_done}, 32'h2);
    end
    tick(6'b101011, 6'd0, 1'b1, 1'b0);
    chk("sw_rdy_s5", {28'd0, state}, 32'd5);
    chk("sw_rdy_wr", {30'd0, memwrite, instr_done}, 32'h3);

    // second sw, reset during MEMWR stall
    tick(6'b101011, 6'd0, 1'b1, 1'b0);
    chk("sw2_s0", {28'd0, state}, 32'd0);
    tick(6'b101011, 6'd0, 1'b1, 1'b0);
    tick(6'b101011, 6'd0, 1'b1, 1'b0);
    tick(6'b101011, 6'd0, 1'b0, 1'b0);
    chk("sw2_s5", {28'd0, state}, 32'd5);
    chk("sw2_wr", {31'd0, memwrite}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {28'd0, state}, 32'd0);
    chk("mid_rst_strobes", {29'd0, memwrite, memread, instr_done}, 32'd0);
    #1 rst_n = 1'b1;
    tick(6'b111111, 6'd0, 1'b1, 1'b0);
    chk("post_rst_s0", {28'd0, state}, 32'd0);

    // unknown opcode
    tick(6'b111111, 6'd0, 1'b1, 1'b0);
    chk("ill_s1", {28'd0, state}, 32'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_dec_done", {31'd0, instr_done}, 32'd0);
    for (int i = 0; i < 11; i++) begin
      tick(6'b000000, 6'd0, 1'b1, 1'b0);
      chk("trap_s13", {28'd0, state}, 32'd13);
      chk("trap_flags", {28'd0, illegal, instr_done, memread, pcwrite}, 32'h8);
    end
`else
    chk("ill_dec_done", {30'd0, instr_done, illegal}, 32'h2);
    tick(6'b000000, 6'd0, 1'b1, 1'b0);
    chk("ill_back_s0", {28'd0, state}, 32'd0);
    chk("ill_tied0", {31'd0, illegal}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-lite datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Generates the ALUOp pair (aluop1, aluop0) consumed by the ALU control decoder, plus all datapath strobes and mux selects.
- Stalls on a memory ready handshake.

Parameters:
- OP_NORI, 6'b011000, opcode of nori (I-type, executes with ALUOp 11).
- FUNCT_BRV, 6'b010100, R-type funct of brv (PC <= ALU result).
- FUNCT_JMXOR, 6'b100001, R-type funct of jmxor (PC <= ALU result).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcwrite, pcwritecond  out  1 each  PC write / PC write if zero.
- iord  out  1  memory address select (0 = PC, 1 = ALUOut).
- memread, memwrite  out  1 each  memory request strobes.
- irwrite  out  1  instruction register load.
- memtoreg, regdst, regwrite  out  1 each  register-file controls.
- alusrca  out  1  ALU A select.
- alusrcb  out  2  ALU B select (00 reg, 01 const 4, 10 signext imm, 11 imm<<2).
- pcsource  out  2  PC mux (00 ALU, 01 ALUOut, 10 jump target, 11 ALUOut register-jump).
- aluop1, aluop0  out  1 each  ALUOp to ALU control decoder.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  unknown opcode trap flag.
- state  out  4  current state, for debug.

Behaviour:
- Reset: asynchronous, active-low. State <= FETCH (0).
  - While rst_n = 0, all strobes are forced 0: pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite, instr_done, illegal.
  - Selects take FETCH values.
- Outputs are Moore-decoded from state. Exception: strobes marked "on ready" are ANDed with mem_ready.
- Unlisted outputs are 0 in every state.
- ALUOp encoding: 00 add, 01 sub, 10 R-type (funct decoded downstream), 11 nori.
- States and transitions:
  - FETCH(0): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00; irwrite and pcwrite on ready. Holds while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): alusrca=0, alusrcb=11, aluop=00. Next state by op:
    - lw/sw (100011/101011) -> MEMADR
    - 000000 -> RTEXEC
    - 000100 -> BEQ
    - 000010 -> JUMP
    - OP_NORI -> IEXEC
    - other -> see Optional Feature.
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00. Next MEMRD if op=lw, else MEMWR.
  - MEMRD(3): memread=1, iord=1. Holds until mem_ready; then MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0, instr_done=1. Next FETCH.
  - MEMWR(5): memwrite=1, iord=1. Holds until mem_ready; on ready instr_done=1, next FETCH.
  - RTEXEC(6): alusrca=1, alusrcb=00, aluop=10. Next RTPC if funct is FUNCT_BRV or FUNCT_JMXOR, else RTWB.
  - RTWB(7): regwrite=1, regdst=1, memtoreg=0, instr_done=1. Next FETCH.
  - RTPC(12): pcwrite=1, pcsource=11, instr_done=1. Next FETCH.
  - BEQ(8): alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01, instr_done=1. Next FETCH.
  - JUMP(9): pcwrite=1, pcsource=10, instr_done=1. Next FETCH.
  - IEXEC(10): alusrca=1, alusrcb=10, aluop=11. Next IWB.
  - IWB(11): regwrite=1, regdst=0, memtoreg=0, instr_done=1. Next FETCH.
  - TRAP(13): see Optional Feature.
- Latencies with mem_ready tied 1:
  - lw 5 cycles; sw, R-type, RTPC, nori 4 cycles; beq, j 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Boundary conditions:
  - mem_ready=1 outside FETCH, MEMRD and MEMWR is ignored.
  - op and funct are sampled only in DECODE, MEMADR and RTEXEC.
  - Reset mid-instruction aborts it with no further strobes and resumes at FETCH.
  - Undefined state codes (14, 15) go to FETCH next cycle with all strobes 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP(13). TRAP holds illegal=1 with all other strobes 0, remains until reset, and does not pulse instr_done.
- Undefined: an unknown opcode in DECODE -> FETCH with instr_done=1 in the DECODE cycle (instruction treated as a NOP, no state 13). illegal is tied 0.

Test Plan:
- Reset, op=100011, mem_ready=1 -> states 0,1,2,3,4,0. In MEMWB: regwrite=1, memtoreg=1; exactly one instr_done pulse.
- op=000000, funct=100010 -> RTEXEC with aluop1/aluop0=1/0, then RTWB with regwrite=1, regdst=1; 4 cycles total.
- op=000000, funct=FUNCT_BRV -> RTEXEC then RTPC with pcwrite=1, pcsource=11; regwrite stays 0.
- op=000100, zero=1 -> BEQ cycle with aluop=01, pcwritecond=1, pcsource=01; 3 cycles. op=OP_NORI -> IEXEC with aluop=11.
- op=101011, mem_ready low 3 cycles in MEMWR -> memwrite held 4 cycles; instr_done only on the ready cycle. rst_n pulsed low mid-MEMWR -> memwrite drops immediately, state=0.
- op=6'b111111: with ILLEGAL_TRAP_EN -> state 13, illegal=1 persists 10+ cycles. Without it -> back to FETCH after DECODE with instr_done=1.
